// File: rtl/load_store_queue.sv
// In-order load/store queue with a fixed per-entry memory latency.
// Optional sticky overflow detection is enabled by defining LSQ_OVERFLOW_DETECT_EN.
module load_store_queue #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned REG_W   = 4,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              queue_write_en,
   input  logic              instr_bit_in,
   input  logic [ADDR_W-1:0] enq_addr,
   input  logic [DATA_W-1:0] enq_data,
   input  logic [REG_W-1:0]  enq_reg,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              done_bit,
   output logic              instr_bit_out,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [REG_W-1:0]  wb_reg,
   output logic [DATA_W-1:0] wb_data,
   output logic              full,
   output logic              empty,
   output logic              overflow
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned NW = PW + 1;
   localparam int unsigned CW = $clog2(MEM_LAT) + 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic              type_q [DEPTH];
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [REG_W-1:0]  reg_q  [DEPTH];

   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [NW-1:0] count_q, count_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    state_q, state_d;
   logic          pop, enq;

   assign full  = (count_q == NW'(DEPTH));
   assign empty = (count_q == '0);
   assign pop   = (state_q == StDone);
   // A pop in the same cycle frees the slot, so a full queue may still accept.
   assign enq   = queue_write_en && (!full || pop);

   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      if (enq) wp_d = wp_q + PW'(1);
      if (pop) rp_d = rp_q + PW'(1);
      if (enq && !pop) count_d = count_q + NW'(1);
      else if (!enq && pop) count_d = count_q - NW'(1);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               state_d = StWait;
               cnt_d   = CW'(MEM_LAT - 1);
            end
         end
         StWait: begin
            if (cnt_q == '0) state_d = StDone;
            else cnt_d = cnt_q - CW'(1);
         end
         StDone: begin
            if (count_d != '0) begin
               state_d = StWait;
               cnt_d   = CW'(MEM_LAT - 1);
            end else begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && enq) begin
         type_q[wp_q] <= instr_bit_in;
         addr_q[wp_q] <= enq_addr;
         data_q[wp_q] <= enq_data;
         reg_q[wp_q]  <= enq_reg;
      end
   end

   assign done_bit      = pop;
   assign instr_bit_out = pop ? type_q[rp_q] : 1'b0;
   assign mem_addr      = empty ? '0 : addr_q[rp_q];
   assign mem_wdata     = empty ? '0 : data_q[rp_q];
   assign wb_reg        = empty ? '0 : reg_q[rp_q];
   assign wb_data       = mem_rdata;

`ifdef LSQ_OVERFLOW_DETECT_EN
   logic overflow_q;
   always_ff @(posedge clk) begin
      if (reset) overflow_q <= 1'b0;
      else if (queue_write_en && full && !pop) overflow_q <= 1'b1;
   end
   assign overflow = overflow_q;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: doc/load_store_queue.md
# load_store_queue

In-order load/store queue (LSQ) that sits between the compute-unit controller and data memory. It accepts LD/ST requests when the controller asserts `queue_write_en`, buffers them in a circular FIFO, and models a fixed memory latency per entry. For one cycle per completed entry it raises `done_bit` and `instr_bit_out`, and the controller turns these into `mem_read_en`, `mem_write_en` and `reg_write_en`. It also drives the memory address and write data, and returns load data to the thread register file.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `ADDR_W`, 8: data-memory address width.
- `DATA_W`, 16: data word width.
- `REG_W`, 4: destination/source register index width.
- `MEM_LAT`, 2: memory latency in cycles; ≥1.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `queue_write_en` input 1: enqueue strobe from the controller.
- `instr_bit_in` input 1: type of the enqueued entry from the controller; 0=LD, 1=ST.
- `enq_addr` input ADDR_W: memory address of the enqueued entry.
- `enq_data` input DATA_W: store data; ignored for LD.
- `enq_reg` input REG_W: LD destination register.
- `mem_rdata` input DATA_W: combinational read data from data memory.
- `done_bit` output 1: head entry completes this cycle.
- `instr_bit_out` output 1: type of the head entry; valid while `done_bit`=1, 0 otherwise.
- `mem_addr` output ADDR_W: head entry address.
- `mem_wdata` output DATA_W: head entry store data.
- `wb_reg` output REG_W: head entry destination register.
- `wb_data` output DATA_W: equals `mem_rdata`; write-back data.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `overflow` output 1: sticky overflow flag (see Configuration).

## Operation
- Storage:
  - DEPTH-entry array of {type, addr, data, reg}.
  - Write pointer `wp`, read pointer `rp`, each log2(DEPTH) bits with natural wrap.
  - Count register, log2(DEPTH)+1 bits.
- Enqueue:
  - Occurs on a `clk` edge where `queue_write_en`=1 and (!`full` or a pop happens in the same cycle).
  - Writes the entry at `wp`; `wp`++.
  - Enqueue while `full` with no pop: entry dropped, state unchanged.
- State machine:
  - IDLE: if count>0 → WAIT and load cnt=MEM_LAT-1.
  - WAIT: if cnt==0 → DONE, else cnt--.
  - DONE: `done_bit`=1 and the head is popped (`rp`++) at the end of the cycle. Next state is WAIT with cnt=MEM_LAT-1 if the post-pop count (including a same-cycle enqueue) is >0; otherwise IDLE.
- Outputs:
  - `mem_addr`, `mem_wdata` and `wb_reg` show the head entry whenever !`empty`, and are 0 when `empty`.
  - These outputs are guaranteed stable only in DONE.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.

## Timing
- Reset values:
  - State IDLE; cnt=0; `wp`=`rp`=0; count=0.
  - `done_bit`=0, `instr_bit_out`=0, `full`=0, `empty`=1, `overflow`=0.
  - `mem_addr`, `mem_wdata`, `wb_reg` = 0.
- Reset asserted mid-operation discards all entries at that edge. No `done_bit` is produced for discarded entries.
- `done_bit`, `instr_bit_out`, `full` and `empty` are decoded from registered state. There is no combinational path from any input to them.
- Latency:
  - An enqueue sampled at the end of cycle 0 into an empty queue yields `done_bit` in cycle 2+MEM_LAT (cycle 4 at the default).
  - Back-to-back entries complete every MEM_LAT+1 cycles.
- `done_bit` is high for exactly one cycle per entry, in FIFO order.
- `full` and `empty` update the cycle after the enqueue or pop edge.
- `wb_data` is combinational from `mem_rdata`. The register file captures it on the DONE edge when `reg_write_en`=1.

## Configuration
- Macro `LSQ_OVERFLOW_DETECT_EN`:
  - When defined: `overflow` is set to 1 on any dropped enqueue (`queue_write_en`=1, `full`=1, no pop in that cycle). It holds until `reset`.
  - When undefined: `overflow` is tied to 0 and no detection logic is generated.
- Queue behaviour is otherwise identical in both builds.

## Test plan
- Reset then idle: `empty`=1, `full`=0, `done_bit`=0 for 10 cycles; all outputs 0.
- Single LD (addr 0x12, reg 3) enqueued in cycle 0, `mem_rdata`=0xBEEF:
  - `done_bit`=1 with `instr_bit_out`=0 in cycle 4 only.
  - `mem_addr`=0x12, `wb_reg`=3, `wb_data`=0xBEEF.
  - `empty`=1 in cycle 5.
- ST (addr 0x40, data 0x1234) followed by LD (addr 0x41) on consecutive cycles:
  - Done pulses in cycles 4 and 7, with `instr_bit_out` 1 then 0.
  - `mem_addr` is 0x40 then 0x41.
- Fill 4 entries, then a 5th enqueue while `full` with no pop:
  - The 5th entry is dropped; exactly 4 done pulses follow.
  - With `LSQ_OVERFLOW_DETECT_EN`, `overflow`=1 and stays 1; without it, `overflow`=0.
- Enqueue while `full` in a DONE cycle: accepted, count stays 4, and all 5 entries complete in order. This checks pointer wrap past index 3.
- Reset asserted in a WAIT cycle with 3 entries queued: the next cycle shows `empty`=1, IDLE and `done_bit`=0. A new LD afterwards completes with the standard 2+MEM_LAT latency.
